// File: rtl/framebuffer_writer_pkg.sv
// Shared panel geometry defaults and RGB565 field helpers for the framebuffer writer
// and the HUB75 scanner that reads the same RAM.
package framebuffer_writer_pkg;

    localparam int unsigned WIDTH_DEF   = 64;
    localparam int unsigned HEIGHT_DEF  = 32;
    localparam int unsigned TIMEOUT_DEF = 65535;
    localparam int unsigned PIXEL_W     = 16;

    typedef logic [PIXEL_W-1:0] rgb565_t;

    function automatic logic [4:0] rgb565_r(input rgb565_t px);
        return px[15:11];
    endfunction

    function automatic logic [5:0] rgb565_g(input rgb565_t px);
        return px[10:5];
    endfunction

    function automatic logic [4:0] rgb565_b(input rgb565_t px);
        return px[4:0];
    endfunction

endpackage

// File: rtl/framebuffer_writer_sync_rise_detect.sv
// Three-flop synchroniser with a rising-edge pulse on the synchronised signal.
// PRESET lets a signal held high across reset produce no edge.
module sync_rise_detect #(
    parameter logic PRESET = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = async_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= PRESET;
            s2_q <= PRESET;
            s3_q <= PRESET;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/framebuffer_writer.sv
// Writes synchronised SPI pixel words in raster order into the back half of a
// double-buffered framebuffer, flipping halves per frame and resyncing after idle gaps.
module framebuffer_writer
    import framebuffer_writer_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned HEIGHT  = HEIGHT_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned X_W     = $clog2(WIDTH),
    parameter int unsigned Y_W     = $clog2(HEIGHT),
    parameter int unsigned ADDR_W  = 1 + Y_W + X_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       pixel_data,
    input  logic              pixel_clock,
    output logic [ADDR_W-1:0] fb_write_addr,
    output logic [15:0]       fb_write_data,
    output logic              fb_write_en,
    output logic              display_buffer,
    output logic              frame_done
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [X_W-1:0]   X_LAST   = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(HEIGHT - 1);
    localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(TIMEOUT - 1);

    logic rise;

    sync_rise_detect #(
        .PRESET(1'b1)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .async_in(pixel_clock),
        .rise    (rise)
    );

    logic              pend_q, pend_d;
    rgb565_t           cap_q, cap_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [CNT_W-1:0]  idle_q, idle_d;
    logic              disp_q, disp_d;
    logic              flip_pend_q, flip_pend_d;
    logic              frame_done_q, frame_done_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    rgb565_t           wdata_q, wdata_d;

    logic           timeout;
    logic [X_W-1:0] x_eff;
    logic [Y_W-1:0] y_eff;

    always_comb begin
        pend_d       = rise;
        cap_d        = rise ? pixel_data : cap_q;
        x_d          = x_q;
        y_d          = y_q;
        idle_d       = idle_q;
        disp_d       = disp_q;
        flip_pend_d  = 1'b0;
        frame_done_d = 1'b0;
        we_d         = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;

        // Timeout resolves before a coincident word, so that word lands at (0,0).
        timeout = (idle_q == IDLE_MAX);
        x_eff   = timeout ? '0 : x_q;
        y_eff   = timeout ? '0 : y_q;

        if (pend_q) begin
            we_d    = 1'b1;
            addr_d  = {~disp_q, y_eff, x_eff};
            wdata_d = cap_q;
            idle_d  = '0;
            if (x_eff == X_LAST) begin
                x_d = '0;
                if (y_eff == Y_LAST) begin
                    y_d         = '0;
                    flip_pend_d = 1'b1;
                end else begin
                    y_d = y_eff + 1'b1;
                end
            end else begin
                x_d = x_eff + 1'b1;
                y_d = y_eff;
            end
        end else begin
            x_d    = x_eff;
            y_d    = y_eff;
            idle_d = timeout ? idle_q : idle_q + 1'b1;
        end

        if (flip_pend_q) begin
            disp_d       = ~disp_q;
            frame_done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q       <= 1'b0;
            cap_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            idle_q       <= '0;
            disp_q       <= 1'b0;
            flip_pend_q  <= 1'b0;
            frame_done_q <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            pend_q       <= pend_d;
            cap_q        <= cap_d;
            x_q          <= x_d;
            y_q          <= y_d;
            idle_q       <= idle_d;
            disp_q       <= disp_d;
            flip_pend_q  <= flip_pend_d;
            frame_done_q <= frame_done_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign fb_write_addr  = addr_q;
    assign fb_write_data  = wdata_q;
    assign fb_write_en    = we_q;
    assign display_buffer = disp_q;
    assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_framebuffer_writer.sv
// Directed self-checking bench for framebuffer_writer (64x32 panel, shortened idle timeout).
module tb_framebuffer_writer;

    localparam int unsigned TMO = 300;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pixel_data = '0;
    logic        pixel_clock = 1'b0;
    logic [11:0] fb_write_addr;
    logic [15:0] fb_write_data;
    logic        fb_write_en;
    logic        display_buffer;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    framebuffer_writer #(
        .WIDTH  (64),
        .HEIGHT (32),
        .TIMEOUT(TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pixel_data    (pixel_data),
        .pixel_clock   (pixel_clock),
        .fb_write_addr (fb_write_addr),
        .fb_write_data (fb_write_data),
        .fb_write_en   (fb_write_en),
        .display_buffer(display_buffer),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    logic [11:0] log_addr[$];
    logic [15:0] log_data[$];
    int          fd_count = 0;
    int          fd_cycle = -1;
    int          last_we_cycle = -1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fb_write_en) begin
            log_addr.push_back(fb_write_addr);
            log_data.push_back(fb_write_data);
            last_we_cycle = cyc;
        end
        if (frame_done) begin
            fd_count = fd_count + 1;
            fd_cycle = cyc;
        end
    end

    task automatic send_word(input logic [15:0] d);
        @(negedge clk);
        pixel_data  = d;
        pixel_clock = 1'b1;
        repeat (3) @(negedge clk);
        pixel_clock = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++;
        if (fb_write_en !== 1'b0) begin
            n_fail++; $display("FAIL reset_we got=%b exp=0", fb_write_en);
        end
        n_checks++;
        if (fb_write_addr !== 12'h000) begin
            n_fail++; $display("FAIL reset_addr got=%h exp=000", fb_write_addr);
        end
        n_checks++;
        if (fb_write_data !== 16'h0000) begin
            n_fail++; $display("FAIL reset_data got=%h exp=0000", fb_write_data);
        end
        n_checks++;
        if (display_buffer !== 1'b0) begin
            n_fail++; $display("FAIL reset_disp got=%b exp=0", display_buffer);
        end
        n_checks++;
        if (frame_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_fd got=%b exp=0", frame_done);
        end
    endtask

    task automatic test_single();
        int lat = 0;
        bit found = 0;
        int base = log_addr.size();
        @(negedge clk);
        pixel_data  = 16'h1234;
        pixel_clock = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 8 && !found; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (fb_write_en) found = 1;
        end
        n_checks++;
        if (!found || lat != 3) begin
            n_fail++; $display("FAIL single_latency got=%0d found=%0d exp=3", lat, found);
        end
        n_checks++;
        if (fb_write_data !== 16'h1234) begin
            n_fail++; $display("FAIL single_data got=%h exp=1234", fb_write_data);
        end
        n_checks++;
        if (fb_write_addr !== 12'h800) begin
            n_fail++; $display("FAIL single_addr got=%h exp=800", fb_write_addr);
        end
        @(negedge clk);
        n_checks++;
        if (fb_write_en !== 1'b0) begin
            n_fail++; $display("FAIL single_we_width got=%b exp=0", fb_write_en);
        end
        pixel_clock = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++;
        if (log_addr.size() - base != 1) begin
            n_fail++; $display("FAIL single_count got=%0d exp=1", log_addr.size() - base);
        end
    endtask

    task automatic test_full_frame();
        int base;
        int fd0;
        int bad = 0;
        logic [11:0] ea;
        do_reset();
        base = log_addr.size();
        fd0  = fd_count;
        for (int i = 0; i < 2048; i++) send_word(16'(i));
        for (int i = 0; i < 2048; i++) begin
            ea = {1'b1, 11'(i)};
            n_checks++;
            if (base + i >= log_addr.size() || log_addr[base+i] !== ea || log_data[base+i] !== 16'(i)) begin
                n_fail++; bad++;
                if (bad < 5) $display("FAIL frame1_write idx=%0d got_addr=%h exp_addr=%h", i,
                    (base + i < log_addr.size()) ? log_addr[base+i] : 12'hxxx, ea);
            end
        end
        n_checks++;
        if (display_buffer !== 1'b1) begin
            n_fail++; $display("FAIL frame1_disp got=%b exp=1", display_buffer);
        end
        n_checks++;
        if (fd_count - fd0 != 1) begin
            n_fail++; $display("FAIL frame1_fd_count got=%0d exp=1", fd_count - fd0);
        end
        n_checks++;
        if (fd_cycle != last_we_cycle + 1) begin
            n_fail++; $display("FAIL frame1_fd_timing got=%0d exp=%0d", fd_cycle, last_we_cycle + 1);
        end
        send_word(16'h5A5A);
        n_checks++;
        if (log_addr[$] !== 12'h000 || log_data[$] !== 16'h5A5A) begin
            n_fail++; $display("FAIL frame2_first got=%h/%h exp=000/5a5a", log_addr[$], log_data[$]);
        end
    endtask

    task automatic test_second_frame();
        int fd0 = fd_count;
        for (int i = 1; i < 2048; i++) send_word(16'(i + 16'h4000));
        n_checks++;
        if (log_addr[$] !== 12'h7FF || log_data[$] !== 16'h47FF) begin
            n_fail++; $display("FAIL frame2_last got=%h/%h exp=7ff/47ff", log_addr[$], log_data[$]);
        end
        n_checks++;
        if (display_buffer !== 1'b0) begin
            n_fail++; $display("FAIL frame2_disp got=%b exp=0", display_buffer);
        end
        n_checks++;
        if (fd_count - fd0 != 1 || fd_count != 2) begin
            n_fail++; $display("FAIL frame2_fd_count got=%0d exp=2", fd_count);
        end
    endtask

    task automatic test_timeout();
        int fd0 = fd_count;
        for (int i = 0; i < 70; i++) send_word(16'(i));
        n_checks++;
        if (log_addr[$] !== 12'h845) begin
            n_fail++; $display("FAIL idle_pre got=%h exp=845", log_addr[$]);
        end
        repeat (TMO + 10) @(negedge clk);
        send_word(16'hABCD);
        n_checks++;
        if (log_addr[$] !== 12'h800 || log_data[$] !== 16'hABCD) begin
            n_fail++; $display("FAIL idle_resync got=%h/%h exp=800/abcd", log_addr[$], log_data[$]);
        end
        n_checks++;
        if (display_buffer !== 1'b0 || fd_count != fd0) begin
            n_fail++; $display("FAIL idle_noflip disp=%b fd=%0d exp=0/%0d", display_buffer, fd_count, fd0);
        end
    endtask

    task automatic test_reset_held();
        int base;
        @(negedge clk);
        pixel_data  = 16'hDEAD;
        pixel_clock = 1'b1;
        reset       = 1'b1;
        repeat (3) @(negedge clk);
        base  = log_addr.size();
        reset = 1'b0;
        repeat (6) @(negedge clk);
        pixel_clock = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++;
        if (log_addr.size() != base) begin
            n_fail++; $display("FAIL held_spurious got=%0d exp=0", log_addr.size() - base);
        end
        send_word(16'h0F0F);
        n_checks++;
        if (log_addr.size() != base + 1 || log_addr[$] !== 12'h800 || log_data[$] !== 16'h0F0F) begin
            n_fail++; $display("FAIL held_next got=%h/%h exp=800/0f0f", log_addr[$], log_data[$]);
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        for (int i = 0; i < 2048; i++) send_word(16'(i));
        n_checks++;
        if (display_buffer !== 1'b1) begin
            n_fail++; $display("FAIL mid_pre_disp got=%b exp=1", display_buffer);
        end
        for (int i = 0; i < 100; i++) send_word(16'(i));
        n_checks++;
        if (log_addr[$] !== 12'h063) begin
            n_fail++; $display("FAIL mid_pre_addr got=%h exp=063", log_addr[$]);
        end
        do_reset();
        @(negedge clk);
        n_checks++;
        if (display_buffer !== 1'b0 || fb_write_en !== 1'b0 || fb_write_addr !== 12'h000 ||
            fb_write_data !== 16'h0000 || frame_done !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_outs got=%b%b%h%h%b exp=00000000",
                display_buffer, fb_write_en, fb_write_addr, fb_write_data, frame_done);
        end
        send_word(16'hBEEF);
        n_checks++;
        if (log_addr[$] !== 12'h800 || log_data[$] !== 16'hBEEF) begin
            n_fail++; $display("FAIL mid_next got=%h/%h exp=800/beef", log_addr[$], log_data[$]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_frame();
        test_second_frame();
        test_timeout();
        test_reset_held();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
